// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, divide-op encoding and helpers for the EX-stage divider.
package div_unit_pkg;
  localparam int XLEN = 32;
  localparam int STALL_W = 6;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} div_op_e;
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring RV32M divider that stalls the pipeline while busy.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_en,
  input  logic            div_signed,
  input  logic            div_rem,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stallreq_ex,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);
  typedef enum logic [1:0] {IDLE, BUSY, SPECIAL, DONE} state_t;
  state_t state;
  logic [XLEN-1:0] rem, quo, dvs, rem_nx, quo_nx, fixed;
  logic [$clog2(XLEN)-1:0] cnt;
  logic [XLEN:0] diff;
  logic rem_sel, neg_q, neg_r, a_neg, b_neg, ovf;
  assign a_neg = div_signed & src_a[XLEN-1];
  assign b_neg = div_signed & src_b[XLEN-1];
  assign ovf = div_signed & (src_a == XMIN) & (src_b == '1);
  assign stallreq_ex = rst_n & div_en & (state != DONE);
  // Partial remainder is always below the divisor, so XLEN+1 bits hold the trial subtraction.
  always_comb begin
    diff = {rem, quo[XLEN-1]} - {1'b0, dvs};
    rem_nx = diff[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : diff[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], ~diff[XLEN]};
    fixed = rem_sel ? cond_neg(rem_nx, neg_r) : cond_neg(quo_nx, neg_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (div_en) begin
          rem_sel <= div_rem;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dvs <= cond_neg(src_b, b_neg);
          cnt <= ($clog2(XLEN))'(XLEN - 1);
          // Specials park their final quotient/remainder in the datapath registers.
          if (src_b == '0 || ovf) begin
            state <= SPECIAL;
            rem <= ovf ? '0 : src_a;
            quo <= ovf ? XMIN : '1;
          end else begin
            state <= BUSY;
            rem <= '0;
            quo <= cond_neg(src_a, a_neg);
          end
        end
        BUSY: if (!div_en) state <= IDLE;
        else begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            result <= fixed;
            result_valid <= 1'b1;
          end
        end
        SPECIAL: begin
          state <= DONE;
          result <= rem_sel ? rem : quo;
          result_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
